// File: rtl/multi_stream_buffer_if.sv
// Request, AXI read-address and AXI read-data signals of the multi-stream prefetch buffer.
// slave = buffer side, master = requester/memory side.
interface multi_stream_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [3:0]            ar_id;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ready;

    modport slave (
        input  req_valid, req_addr, ar_ready, r_valid, r_data,
        output hit, rdata, ar_valid, ar_addr, ar_len, ar_id, r_ready
    );
    modport master (
        output req_valid, req_addr, ar_ready, r_valid, r_data,
        input  hit, rdata, ar_valid, ar_addr, ar_len, ar_id, r_ready
    );
endinterface

// File: rtl/multi_stream_buffer.sv
// Multi-stream next-line instruction prefetch buffer: per-stream line FIFOs, LRU allocation,
// one outstanding AXI burst. Define STREAM_BUFFER_STATS_EN to add hit/miss counters.
module multi_stream_buffer #(
    parameter int NUM_STREAMS        = 4,
    parameter int DEPTH              = 4,
    parameter int BLOCK_OFFSET_WIDTH = 2,
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32
) (
    input  logic clk,
    input  logic rst_n,
    multi_stream_buffer_if.slave bus
`ifdef STREAM_BUFFER_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int LINE_WORDS = 1 << BLOCK_OFFSET_WIDTH;
    localparam int TAG_WIDTH  = ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2;
    localparam int SW         = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int PW         = $clog2(DEPTH);
    localparam int CW         = PW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
    typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    line_t lines_q [NUM_STREAMS][DEPTH];
    tag_t  ltag_q  [NUM_STREAMS][DEPTH];
    line_t stage_q;

    logic [NUM_STREAMS-1:0][PW-1:0] head_q, tail_q;
    logic [NUM_STREAMS-1:0][CW-1:0] cnt_q;
    logic [NUM_STREAMS-1:0]         active_q;
    tag_t [NUM_STREAMS-1:0]         ntag_q;
    logic [NUM_STREAMS-1:0][SW-1:0] rank_q;   // 0 = least recently used

    state_e                        state_q, state_d;
    logic [SW-1:0]                 sel_q, sel_d, rr_q, rr_d;
    tag_t                          stag_q, stag_d;
    logic                          drop_q, drop_d;
    logic [BLOCK_OFFSET_WIDTH-1:0] beat_q, beat_d;

    tag_t                          req_tag;
    logic [BLOCK_OFFSET_WIDTH-1:0] req_off;
    logic                          hit_any, miss, pop, found_free, pick_ok, push, ar_fire;
    logic [SW-1:0]                 hit_id, vic_id, lru_id, touch_id, pick_id, idx;
    line_t                         push_line;

    assign req_tag = bus.req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_off = bus.req_addr[BLOCK_OFFSET_WIDTH+1:2];

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        hit_any    = 1'b0;
        hit_id     = '0;
        vic_id     = '0;
        lru_id     = '0;
        found_free = 1'b0;
        for (int s = NUM_STREAMS-1; s >= 0; s--) begin
            if (bus.req_valid && cnt_q[s] != '0 && ltag_q[s][head_q[s]] == req_tag) begin
                hit_any = 1'b1;
                hit_id  = SW'(s);
            end
            if (rank_q[s] == '0) lru_id = SW'(s);
            if (!active_q[s]) begin
                found_free = 1'b1;
                vic_id     = SW'(s);
            end
        end
        if (!found_free) vic_id = lru_id;
    end

    assign miss      = bus.req_valid && !hit_any;
    assign pop       = hit_any && (req_off == '1);
    assign touch_id  = hit_any ? hit_id : vic_id;
    assign bus.hit   = hit_any;
    assign bus.rdata = hit_any ? lines_q[hit_id][head_q[hit_id]][req_off] : '0;

    always_comb begin
        pick_ok = 1'b0;
        pick_id = '0;
        idx     = '0;
        for (int k = NUM_STREAMS; k >= 1; k--) begin
            idx = SW'((int'(rr_q) + k) % NUM_STREAMS);
            if (active_q[idx] && cnt_q[idx] != CW'(DEPTH)) begin
                pick_ok = 1'b1;
                pick_id = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        stag_d  = stag_q;
        drop_d  = drop_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        push    = 1'b0;
        ar_fire = 1'b0;
        case (state_q)
            IDLE: if (pick_ok) begin
                sel_d   = pick_id;
                // A stream reallocated on this same edge must fetch from its new address.
                stag_d  = (miss && vic_id == pick_id) ? req_tag + 1'b1 : ntag_q[pick_id];
                rr_d    = pick_id;
                drop_d  = 1'b0;
                beat_d  = '0;
                state_d = ADDR;
            end
            ADDR: begin
                if (miss && vic_id == sel_q) drop_d = 1'b1;
                if (bus.ar_ready) begin
                    ar_fire = 1'b1;
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (miss && vic_id == sel_q) drop_d = 1'b1;
                if (bus.r_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        push    = !drop_d;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_line              = stage_q;
        push_line[LINE_WORDS-1] = bus.r_data;
    end

    assign bus.ar_valid = (state_q == ADDR);
    assign bus.ar_addr  = {stag_q, {(BLOCK_OFFSET_WIDTH+2){1'b0}}};
    assign bus.ar_len   = 8'(LINE_WORDS-1);
    assign bus.ar_id    = 4'd2;
    assign bus.r_ready  = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            stag_q  <= '0;
            drop_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            stag_q  <= stag_d;
            drop_q  <= drop_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            active_q <= '0;
            ntag_q   <= '0;
            for (int s = 0; s < NUM_STREAMS; s++) rank_q[s] <= SW'(s);
        end else begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                if (miss && vic_id == SW'(s)) begin
                    active_q[s] <= 1'b1;
                    ntag_q[s]   <= req_tag + 1'b1;
                    head_q[s]   <= '0;
                    tail_q[s]   <= '0;
                    cnt_q[s]    <= '0;
                end else begin
                    if (pop && hit_id == SW'(s)) head_q[s] <= head_q[s] + 1'b1;
                    if (push && sel_q == SW'(s)) tail_q[s] <= tail_q[s] + 1'b1;
                    if ((pop && hit_id == SW'(s)) && !(push && sel_q == SW'(s)))
                        cnt_q[s] <= cnt_q[s] - 1'b1;
                    else if (!(pop && hit_id == SW'(s)) && (push && sel_q == SW'(s)))
                        cnt_q[s] <= cnt_q[s] + 1'b1;
                    if (ar_fire && !drop_d && sel_q == SW'(s)) ntag_q[s] <= stag_q + 1'b1;
                end
                if (hit_any || miss) begin
                    if (touch_id == SW'(s))                rank_q[s] <= SW'(NUM_STREAMS-1);
                    else if (rank_q[s] > rank_q[touch_id]) rank_q[s] <= rank_q[s] - 1'b1;
                end
            end
        end
    end

    // Line storage and burst staging carry no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (state_q == DATA && bus.r_valid) stage_q[beat_q] <= bus.r_data;
        if (push) begin
            lines_q[sel_q][tail_q[sel_q]] <= push_line;
            ltag_q[sel_q][tail_q[sel_q]]  <= stag_q;
        end
    end

`ifdef STREAM_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_any && hit_count != '1) hit_count  <= hit_count + 1'b1;
            if (miss && miss_count != '1)   miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_multi_stream_buffer.sv
// Randomized scoreboard bench for multi_stream_buffer against a queue-based stream model.
module tb_multi_stream_buffer;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int LW = 4;
    localparam int TW = 28;

    typedef logic [TW-1:0] tag_t;
    typedef struct {
        logic        hit;
        logic [31:0] rdata;
        logic        arv;
        logic [31:0] araddr;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_stream_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef STREAM_BUFFER_STATS_EN
    logic [31:0] hit_count, miss_count;
    multi_stream_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                             .hit_count(hit_count), .miss_count(miss_count));
`else
    multi_stream_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    // Reference model: each stream is a queue of line tags, LRU is a queue (front = oldest).
    tag_t fifo [N][$];
    bit   act  [N];
    tag_t ntag [N];
    int   lru  [$];
    int   st, sel, beats, rr;
    bit   drop;
    tag_t stag;
    int   mhits, mmiss;

    exp_t expq [$];
    int   checks = 0;
    int   errors = 0;
    int   ar_pct, r_pct;

    function automatic logic [31:0] memword(tag_t t, int off);
        logic [31:0] a;
        a = {t, 2'(off), 2'b00};
        return (a * 32'h9E3779B1) ^ 32'h3C5A96E1;
    endfunction

    function automatic void touch(int s);
        int pos = -1;
        for (int i = 0; i < lru.size(); i++) if (lru[i] == s) pos = i;
        if (pos >= 0) lru.delete(pos);
        lru.push_back(s);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < N; s++) begin
            fifo[s].delete();
            act[s]  = 1'b0;
            ntag[s] = '0;
        end
        lru = {0, 1, 2, 3};
        st = 0; sel = 0; beats = 0; rr = 0; drop = 1'b0; stag = '0;
        mhits = 0; mmiss = 0;
    endfunction

    function automatic void model_step(bit rv, logic [31:0] addr, bit arr, bit rvl);
        exp_t e;
        tag_t t;
        int   off, hs, fl, pk, pu;
        t  = addr[31:4];
        off = int'(addr[3:2]);
        hs = -1; fl = -1; pk = -1; pu = -1;
        if (rv) for (int s = 0; s < N; s++)
            if (hs < 0 && fifo[s].size() > 0 && fifo[s][0] == t) hs = s;
        e.hit    = (hs >= 0);
        e.rdata  = (hs >= 0) ? memword(t, off) : 32'h0;
        e.arv    = (st == 1);
        e.araddr = {stag, 4'h0};
        e.hc     = mhits;
        e.mc     = mmiss;
        expq.push_back(e);

        if (rv && hs >= 0) mhits++;
        if (rv && hs < 0) begin
            mmiss++;
            for (int s = N-1; s >= 0; s--) if (!act[s]) fl = s;
            if (fl < 0) fl = lru[0];
        end
        case (st)
            0: begin
                for (int k = N; k >= 1; k--)
                    if (act[(rr+k)%N] && fifo[(rr+k)%N].size() < D) pk = (rr+k)%N;
                if (pk >= 0) begin
                    sel  = pk;
                    stag = (fl == pk) ? tag_t'(t + 1) : ntag[pk];
                    rr   = pk;
                    drop = 1'b0;
                    st   = 1;
                end
            end
            1: begin
                if (fl == sel) drop = 1'b1;
                if (arr) begin
                    if (!drop) ntag[sel] = tag_t'(stag + 1);
                    beats = 0;
                    st = 2;
                end
            end
            default: begin
                if (fl == sel) drop = 1'b1;
                if (rvl) begin
                    beats++;
                    if (beats == LW) begin
                        if (!drop) pu = sel;
                        st = 0;
                    end
                end
            end
        endcase
        if (hs >= 0) begin
            touch(hs);
            if (off == LW-1) void'(fifo[hs].pop_front());
        end
        if (fl >= 0) begin
            fifo[fl].delete();
            act[fl]  = 1'b1;
            ntag[fl] = tag_t'(t + 1);
            touch(fl);
        end
        if (pu >= 0) fifo[pu].push_back(stag);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r, s;
        logic [1:0] o;
        r = int'($urandom_range(0, 99));
        s = int'($urandom_range(0, N-1));
        o = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
        if (r < 65 && fifo[s].size() > 0) return {fifo[s][0], o, 2'b00};
        if (r < 75 && fifo[s].size() > 1) return {fifo[s][1], o, 2'b00};
        if (r < 78) return {28'hFFFFFFF, o, 2'b00};
        return {28'h0000100 + 28'($urandom_range(0, 47)), o, 2'b00};
    endfunction

    task automatic do_cycle(input bit rv, input logic [31:0] addr);
        bit arr, rvl;
        @(negedge clk);
        arr = (int'($urandom_range(0, 99)) < ar_pct);
        rvl = (int'($urandom_range(0, 99)) < r_pct);
        bus.req_valid = rv;
        bus.req_addr  = addr;
        bus.ar_ready  = arr;
        bus.r_valid   = rvl;
        bus.r_data    = (st == 2) ? memword(stag, beats) : $urandom;
        #1 model_step(rv, addr, arr, rvl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        bus.req_valid = 1'b1;
        bus.req_addr  = $urandom;
        bus.r_valid   = 1'b1;
        bus.ar_ready  = 1'b1;
        #1;
        e.hit = 1'b0; e.rdata = '0; e.arv = 1'b0; e.araddr = '0; e.hc = '0; e.mc = '0;
        expq.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.r_valid   = 1'b0;
        bus.ar_ready  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act_v, exp_v);
        end
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("hit", 32'(bus.hit), 32'(e.hit));
                chk("rdata", bus.rdata, e.rdata);
                chk("ar_valid", 32'(bus.ar_valid), 32'(e.arv));
                chk("r_ready", 32'(bus.r_ready), 32'h1);
                if (e.arv) begin
                    chk("ar_addr", bus.ar_addr, e.araddr);
                    chk("ar_len", 32'(bus.ar_len), 32'd3);
                    chk("ar_id", 32'(bus.ar_id), 32'd2);
                end
`ifdef STREAM_BUFFER_STATS_EN
                chk("hit_count", hit_count, e.hc);
                chk("miss_count", miss_count, e.mc);
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.ar_ready = 1'b0;
        bus.r_valid = 1'b0; bus.r_data = '0;
        model_reset();
        ar_pct = 100; r_pct = 100;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single miss then idle: four prefetches, then stall until a pop.
        do_cycle(1'b1, 32'h0000_1000);
        idle(40);
        do_cycle(1'b1, 32'h0000_1010);
        do_cycle(1'b1, 32'h0000_1018);
        do_cycle(1'b1, 32'h0000_101C);
        idle(20);

        // Fill four streams, hit stream 0, replace the LRU stream.
        apply_reset();
        do_cycle(1'b1, 32'h0000_1000);
        do_cycle(1'b1, 32'h0000_2000);
        do_cycle(1'b1, 32'h0000_3000);
        do_cycle(1'b1, 32'h0000_4000);
        idle(120);
        do_cycle(1'b1, 32'h0000_1010);
        do_cycle(1'b1, 32'h0000_5000);
        do_cycle(1'b1, 32'h0000_101C);
        idle(30);
        do_cycle(1'b1, 32'h0000_5010);

        // Top-of-space miss wraps the next-line address.
        apply_reset();
        do_cycle(1'b1, 32'hFFFF_FFF0);
        idle(12);
        do_cycle(1'b1, 32'h0000_0004);

        // Randomized traffic with back-pressure and spurious beats.
        ar_pct = 60; r_pct = 70;
        for (int i = 0; i < 4000; i++)
            do_cycle(int'($urandom_range(0, 99)) < 45, rand_addr());

        // Reset while a burst is in its data phase.
        n = 0;
        while (st != 2 && n < 300) begin
            do_cycle(int'($urandom_range(0, 99)) < 45, rand_addr());
            n++;
        end
        checks++;
        if (st != 2) begin
            errors++;
            $display("FAIL mid_burst_reach: got state %0d expected 2", st);
        end
        apply_reset();
        for (int i = 0; i < 600; i++)
            do_cycle(int'($urandom_range(0, 99)) < 45, rand_addr());

        idle(3);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_stream_buffer.md
MULTI_STREAM_BUFFER -- requirements
Module: multi_stream_buffer

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 4, number of independent next-line streams (power of two, 1..8).
REQ-002 SHALL have parameter DEPTH, default 4, lines per stream FIFO (power of two, 2..16).
REQ-003 SHALL have parameter BLOCK_OFFSET_WIDTH, default 2, giving LINE_WORDS = 2**BLOCK_OFFSET_WIDTH words per line.
REQ-004 SHALL have parameters ADDR_WIDTH, default 32, and DATA_WIDTH, default 32; TAG_WIDTH = ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2.
REQ-005 SHALL use one clock and an asynchronous active-low reset:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  req_valid  in  1  lookup request this cycle
  req_addr  in  ADDR_WIDTH  byte address of requested instruction word
  hit  out  1  request served from a stream head
  rdata  out  DATA_WIDTH  requested word, valid when hit
  ar_valid  out  1  AXI read-address valid
  ar_ready  in  1  AXI read-address ready
  ar_addr  out  ADDR_WIDTH  line-aligned burst address
  ar_len  out  8  burst length, constant LINE_WORDS-1
  ar_id  out  4  constant 4'd2
  r_valid  in  1  AXI read-data valid
  r_data  in  DATA_WIDTH  AXI read data
  r_ready  out  1  constant 1

Function
REQ-006 SHALL split req_addr as {tag, word_offset, 2'b00}.
REQ-007 SHALL assert hit combinationally when req_valid and any stream's head line is valid with tag equal; lowest stream index wins on multiple matches.
REQ-008 SHALL drive rdata = head word at word_offset of the hit stream, else 0.
REQ-009 SHALL pop the hit stream's head at the clock edge when hit and word_offset == LINE_WORDS-1.
REQ-010 SHALL, on miss (req_valid and not hit), allocate the lowest-index inactive stream, else the LRU stream; flush its FIFO, set its next_tag = tag+1 (mod 2**TAG_WIDTH), mark it active.
REQ-011 SHALL make a stream MRU on every hit or allocation; LRU order updates at the clock edge.
REQ-012 SHALL run prefetch FSM IDLE -> ADDR -> DATA -> IDLE, at most one burst outstanding.
REQ-013 IDLE: select round-robin (starting after last-served index) an active stream with occupancy < DEPTH; if found, latch stream id and next_tag, go ADDR; if none, stay IDLE.
REQ-014 ADDR: ar_valid=1, ar_addr={latched tag, zeros}; on ar_ready, increment that stream's next_tag, go DATA; ar_valid SHALL be 0 outside ADDR.
REQ-015 DATA: capture r_data beats in order into a staging line; on the LINE_WORDS-th beat, push the line into the latched stream's FIFO, go IDLE.
REQ-016 SHALL set a drop flag if the latched stream is flushed in ADDR or DATA (including the edge of the completing beat); a dropped line SHALL NOT be pushed, the burst SHALL still be completed.
REQ-017 Pop and push on the same stream in the same cycle SHALL both take effect; occupancy unchanged.
REQ-018 r_valid outside DATA SHALL be ignored.
REQ-019 Head/tail pointers SHALL wrap modulo DEPTH; next_tag SHALL wrap modulo 2**TAG_WIDTH.

Reset
REQ-020 rst_n low SHALL immediately clear all stream valid/active bits, pointers, occupancies, drop flag, round-robin pointer; FSM to IDLE; LRU order index 0 least recent; hit=0, rdata=0, ar_valid=0.
REQ-021 Reset mid-burst SHALL abandon the burst; beats arriving after reset SHALL be ignored.

Configuration
REQ-022 With STREAM_BUFFER_STATS_EN defined, SHALL add outputs hit_count[31:0] and miss_count[31:0], incrementing per hit/miss cycle, saturating at 0xFFFFFFFF, reset to 0.
REQ-023 Without STREAM_BUFFER_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification (defaults)
REQ-024 Reset; miss 0x1000 -> stream 0 allocated; AR 0x1010, ar_len 3, ar_id 2; after beats A,B,C,D, req 0x1010 -> hit, rdata A; req 0x101C -> rdata D, head popped.
REQ-025 Miss 0x1000, no further requests -> exactly four ARs 0x1010,0x1020,0x1030,0x1040; no fifth until a pop.
REQ-026 Misses 0x1000,0x2000,0x3000,0x4000 fill streams 0..3; hit 0x1010; miss 0x5000 -> stream 1 replaced, next AR for it 0x5010.
REQ-027 Burst for stream 0 in DATA, miss reallocates stream 0 -> beats dropped, req at dropped line address misses.
REQ-028 Miss 0xFFFFFFF0 -> AR 0x00000000.
REQ-029 STREAM_BUFFER_STATS_EN defined, 1 miss then 3 hits -> miss_count 1, hit_count 3; reset -> both 0.
